// File: rtl/wm_pkg.sv
// ---------------------------------------------------------------------------
// wm_pkg : shared types and LFSR step helper for the watermark keystream path
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wm_state_e;

  localparam int MODE_RAW  = 0;
  localparam int MODE_TERN = 1;

  // One Galois step on a zero-extended state; callers truncate to their width.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state, input logic [31:0] taps);
    return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wm_sym_map.sv
// ---------------------------------------------------------------------------
// wm_sym_map : raw / ternary symbol mapping, shared with the extractor
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wm_sym_map
  import wm_pkg::*;
#(
  parameter int SYM_W = 2,
  parameter int MODE  = MODE_RAW
) (
  input  logic [SYM_W-1:0] raw_i,
  output logic [SYM_W-1:0] sym_o
);

  generate
    if (MODE == MODE_TERN && SYM_W == 2) begin : g_tern
      // Folds code 11 onto 01 so only 00/01/10 ever leave the block.
      logic w_par;
      assign w_par = raw_i[1] ^ raw_i[0];
      assign sym_o = {w_par, (w_par ? 1'b0 : raw_i[0])};
    end else begin : g_raw
      assign sym_o = raw_i;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/wm_keystream_gen.sv
// ---------------------------------------------------------------------------
// wm_keystream_gen : key-seeded Galois LFSR emitting framed watermark symbols
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wm_keystream_gen
  import wm_pkg::*;
#(
  parameter int               LFSR_W      = 8,
  parameter logic [LFSR_W-1:0] TAPS        = 8'hB8,
  parameter logic [LFSR_W-1:0] KEY_DEFAULT = 8'h6A,
  parameter int               SYM_W       = 2,
  parameter int               MODE        = MODE_RAW,
  parameter int               FRAME_LEN   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load_i,
  input  logic [LFSR_W-1:0] key_in_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              cont_i,
  output logic              wm_valid_o,
  input  logic              wm_ready_i,
  output logic [SYM_W-1:0]  wm_data_o,
  output logic              wm_last_o,
  output logic [15:0]       frame_cnt_o,
  output logic              key_zero_o
);

  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  wm_state_e         state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] key_q, key_d;
  logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              key_zero_q, key_zero_d;

  logic [LFSR_W-1:0] w_next;
  logic              w_xfer;
  logic              w_last;

  assign w_last = (state_q == RUN) && (sym_cnt_q == LAST_IDX);
  assign w_xfer = (state_q == RUN) && wm_ready_i;

  // SYM_W unrolled steps so a whole symbol is consumed per transfer.
  always_comb begin
    w_next = lfsr_q;
    for (int i = 0; i < SYM_W; i++) begin
      w_next = LFSR_W'(lfsr_step(32'(w_next), 32'(TAPS)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lfsr_q      <= KEY_DEFAULT;
      key_q       <= KEY_DEFAULT;
      sym_cnt_q   <= '0;
      frame_cnt_q <= '0;
      key_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      key_q       <= key_d;
      sym_cnt_q   <= sym_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      key_zero_q  <= key_zero_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    key_d       = key_q;
    sym_cnt_d   = sym_cnt_q;
    frame_cnt_d = frame_cnt_q;
    key_zero_d  = key_zero_q;

    // A zero key would lock the LFSR, so it is replaced by 1 and flagged.
    if (key_load_i) begin
      if (key_in_i == '0) begin
        key_d      = LFSR_W'(1);
        key_zero_d = 1'b1;
      end else begin
        key_d      = key_in_i;
        key_zero_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d   = RUN;
          lfsr_d    = key_q;
          sym_cnt_d = '0;
        end
      end
      RUN: begin
        if (w_xfer) begin
          if (w_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            sym_cnt_d   = '0;
            lfsr_d      = key_q;
            if (!cont_i) state_d = IDLE;
          end else begin
            lfsr_d    = w_next;
            sym_cnt_d = sym_cnt_q + CNT_W'(1);
          end
        end
        if (stop_i) begin
          state_d   = IDLE;
          sym_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  wm_sym_map #(
    .SYM_W (SYM_W),
    .MODE  (MODE)
  ) u_sym_map (
    .raw_i (lfsr_q[SYM_W-1:0]),
    .sym_o (wm_data_o)
  );

  assign wm_valid_o  = (state_q == RUN);
  assign wm_last_o   = w_last;
  assign frame_cnt_o = frame_cnt_q;
  assign key_zero_o  = key_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_wm_keystream_gen.sv
// ---------------------------------------------------------------------------
// tb_wm_keystream_gen : directed bench, three configurations sharing stimulus
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wm_keystream_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_load, start, stop, cont, wm_ready;
  logic [7:0] key_in;

  logic        a_valid, a_last, a_kz, b_valid, b_last, b_kz, c_valid, c_last, c_kz;
  logic [1:0]  a_data, b_data, c_data;
  logic [15:0] a_fcnt, b_fcnt, c_fcnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // a: raw, 4-symbol frames; b: ternary, 600; c: raw, 600
  wm_keystream_gen #(.LFSR_W(8), .TAPS(8'hB8), .KEY_DEFAULT(8'h6A), .SYM_W(2), .MODE(0), .FRAME_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_load_i(key_load), .key_in_i(key_in), .start_i(start),
    .stop_i(stop), .cont_i(cont), .wm_valid_o(a_valid), .wm_ready_i(wm_ready),
    .wm_data_o(a_data), .wm_last_o(a_last), .frame_cnt_o(a_fcnt), .key_zero_o(a_kz));

  wm_keystream_gen #(.LFSR_W(8), .TAPS(8'hB8), .KEY_DEFAULT(8'h6A), .SYM_W(2), .MODE(1), .FRAME_LEN(600)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_load_i(key_load), .key_in_i(key_in), .start_i(start),
    .stop_i(stop), .cont_i(cont), .wm_valid_o(b_valid), .wm_ready_i(wm_ready),
    .wm_data_o(b_data), .wm_last_o(b_last), .frame_cnt_o(b_fcnt), .key_zero_o(b_kz));

  wm_keystream_gen #(.LFSR_W(8), .TAPS(8'hB8), .KEY_DEFAULT(8'h6A), .SYM_W(2), .MODE(0), .FRAME_LEN(600)) dut_c (
    .clk(clk), .rst_n(rst_n), .key_load_i(key_load), .key_in_i(key_in), .start_i(start),
    .stop_i(stop), .cont_i(cont), .wm_valid_o(c_valid), .wm_ready_i(wm_ready),
    .wm_data_o(c_data), .wm_last_o(c_last), .frame_cnt_o(c_fcnt), .key_zero_o(c_kz));

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [1:0]  data;
    logic        last;
    logic [15:0] fcnt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] step8(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  function automatic logic [1:0] tern(input logic [1:0] s);
    return {s[1] ^ s[0], ((s[1] ^ s[0]) ? 1'b0 : s[0])};
  endfunction

  initial begin
    logic [1:0] raw_exp [4];
    logic [1:0] tern_hand [3];
    logic [7:0] m;

    raw_exp   = '{2'b01, 2'b00, 2'b11, 2'b01};
    tern_hand = '{2'b10, 2'b00, 2'b01};

    vecs[0]  = '{1'b1, 1'b1, 2'b01, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 2'b11, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 2'b11, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 2'b11, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 2'b11, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 2'b11, 1'b0, 16'd0};
    vecs[7]  = '{1'b1, 1'b1, 2'b11, 1'b0, 16'd0};
    vecs[8]  = '{1'b1, 1'b1, 2'b01, 1'b1, 16'd0};
    vecs[9]  = '{1'b1, 1'b1, 2'b01, 1'b0, 16'd1};
    vecs[10] = '{1'b1, 1'b1, 2'b00, 1'b0, 16'd1};
    vecs[11] = '{1'b1, 1'b1, 2'b11, 1'b0, 16'd1};
    vecs[12] = '{1'b1, 1'b1, 2'b01, 1'b1, 16'd1};

    rst_n = 1'b0; key_load = 1'b0; key_in = 8'h00; start = 1'b0;
    stop = 1'b0; cont = 1'b0; wm_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_a_last", a_last, 1'b0);
    chk("rst_a_fcnt", a_fcnt, 16'd0);
    chk("rst_a_kz", a_kz, 1'b0);
    chk("rst_a_data", a_data, 2'b10);
    chk("rst_b_data", b_data, 2'b10);
    chk("rst_c_valid", c_valid, 1'b0);
    rst_n = 1'b1;

    // Key 01, continuous frames with backpressure
    @(negedge clk); key_load = 1'b1; key_in = 8'h01; cont = 1'b1;
    @(negedge clk); key_load = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d_valid", i), a_valid, vecs[i].vld);
      chk($sformatf("vec%0d_data", i), a_data, vecs[i].data);
      chk($sformatf("vec%0d_last", i), a_last, vecs[i].last);
      chk($sformatf("vec%0d_fcnt", i), a_fcnt, vecs[i].fcnt);
      wm_ready = vecs[i].rdy;
      @(negedge clk);
    end
    wm_ready = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("stop_a_valid", a_valid, 1'b0);
    chk("stop_a_fcnt", a_fcnt, 16'd2);
    chk("stop_a_data", a_data, 2'b01);
    chk("stop_b_valid", b_valid, 1'b0);
    chk("stop_b_fcnt", b_fcnt, 16'd0);

    // Single frame, cont=0
    cont = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; wm_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("single_data%0d", k), a_data, raw_exp[k]);
      chk($sformatf("single_last%0d", k), a_last, (k == 3));
      @(negedge clk);
    end
    chk("single_idle_valid", a_valid, 1'b0);
    chk("single_idle_fcnt", a_fcnt, 16'd3);
    wm_ready = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    // Zero key, then key change mid-frame
    key_load = 1'b1; key_in = 8'h00;
    @(negedge clk); key_load = 1'b0;
    chk("kz_set_a", a_kz, 1'b1);
    chk("kz_set_b", b_kz, 1'b1);
    start = 1'b1;
    @(negedge clk); start = 1'b0; wm_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("kz_data%0d", k), a_data, raw_exp[k]);
      chk($sformatf("kz_flag%0d", k), a_kz, (k <= 1));
      key_load = (k == 1);
      key_in   = 8'h6A;
      @(negedge clk);
    end
    key_load = 1'b0;
    chk("kz_idle_valid", a_valid, 1'b0);
    chk("kz_reload_data", a_data, 2'b10);
    chk("kz_fcnt", a_fcnt, 16'd4);
    wm_ready = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;

    // Long run: ternary legality and raw period
    key_load = 1'b1; key_in = 8'h01;
    @(negedge clk); key_load = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; wm_ready = 1'b1;
    m = 8'h01;
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("tern_sym%0d", i), b_data, tern(m[1:0]));
      chk($sformatf("tern_no11_%0d", i), (b_data == 2'b11), 1'b0);
      chk($sformatf("raw_sym%0d", i), c_data, m[1:0]);
      if (i < 3) chk($sformatf("tern_hand%0d", i), b_data, tern_hand[i]);
      if (i == 255) chk("period_sym255", c_data, 2'b01);
      m = step8(step8(m));
      @(negedge clk);
    end

    // Stop with a transfer in the same cycle
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; wm_ready = 1'b0;
    m = step8(step8(m));
    chk("stopx_b_valid", b_valid, 1'b0);
    chk("stopx_b_data", b_data, tern(m[1:0]));
    chk("stopx_c_data", c_data, m[1:0]);
    chk("stopx_b_fcnt", b_fcnt, 16'd0);

    // start and stop together
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("ss_a_valid", a_valid, 1'b0);
    chk("ss_b_valid", b_valid, 1'b0);
    @(negedge clk);
    chk("ss_c_valid", c_valid, 1'b0);

    // Reset mid-frame
    start = 1'b1;
    @(negedge clk); start = 1'b0; wm_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_a_valid", a_valid, 1'b1);
    chk("mid_a_data", a_data, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("arst_a_valid", a_valid, 1'b0);
    chk("arst_a_data", a_data, 2'b10);
    chk("arst_a_fcnt", a_fcnt, 16'd0);
    chk("arst_a_last", a_last, 1'b0);
    chk("arst_b_data", b_data, 2'b10);
    @(negedge clk); rst_n = 1'b1; wm_ready = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
